flex_tap_mac: RTL and testbench

Per-branch multiply-accumulate stage placed directly downstream of the Flex FIR control FSM and its coefficient SP-SRAM. On each 600 kHz sample trigger it shifts the new input sample into a 10-tap delay line and clears its accumulator. It then consumes one coefficient per 12 MHz cycle, multiplies each by the delay-line tap selected by the FSM's tap-select index, and accumulates the products. When the sweep completes, it emits a full-precision branch sum with a one-cycle valid pulse. Four instances, one per SRAM bank, feed the final branch adder.

---
 rtl/flex_tap_mac.sv | 68 ++++++
 tb/tb_flex_tap_mac.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/flex_tap_mac.sv
// flex_tap_mac: per-branch 10-tap delay line and coefficient MAC for the Flex FIR,
// restarted by each sample strobe and emitting one full-precision sum per sweep.
module flex_tap_mac #(
    parameter int P_DW   = 3,
    parameter int P_CW   = 16,
    parameter int P_TAPS = 10,
    parameter int P_AW   = 23
) (
    input  logic                   iClk_12M,
    input  logic                   iRsn,
    input  logic                   iEnDelay,
    input  logic signed [P_DW-1:0] iFirIn,
    input  logic                   iMacEn,
    input  logic [3:0]             iInSel,
    input  logic signed [P_CW-1:0] iCoef,
    output logic signed [P_AW-1:0] oAccOut,
    output logic                   oAccValid,
    output logic                   oBusy,
    output logic                   oOverrun
);
    localparam int PW = P_DW + P_CW;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                 rState, nState;
    logic signed [P_DW-1:0] rTap [P_TAPS];
    logic [3:0]             rCnt;
    logic signed [P_AW-1:0] rAcc, accNext;
    logic signed [PW-1:0]   prod;
    logic                   accept, last;

    // A strobe always wins over a term arriving in the same cycle
    always_comb begin
        accept  = rState == ACC && iMacEn && iInSel == rCnt && !iEnDelay;
        last    = accept && rCnt == 4'(P_TAPS - 1);
        prod    = PW'(rTap[rCnt]) * PW'(iCoef);
        accNext = rAcc + P_AW'(prod);
        nState  = iEnDelay ? ACC : last ? DONE : rState == DONE ? IDLE : rState;
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            rState   <= IDLE;
            rAcc     <= '0;
            rCnt     <= '0;
            oAccOut  <= '0;
            oOverrun <= 1'b0;
            for (int k = 0; k < P_TAPS; k++) rTap[k] <= '0;
        end else begin
            rState   <= nState;
            oOverrun <= iEnDelay && rState == ACC;
            if (iEnDelay) begin
                rTap[0] <= iFirIn;
                for (int k = 1; k < P_TAPS; k++) rTap[k] <= rTap[k-1];
                rAcc <= '0;
                rCnt <= '0;
            end else if (accept) begin
                rAcc <= accNext;
                rCnt <= last ? 4'd0 : rCnt + 4'd1;
            end
            // Output register loads on the final term so it is valid throughout DONE
            if (last) oAccOut <= accNext;
        end
    end

    assign oAccValid = rState == DONE;
    assign oBusy     = rState == ACC;
endmodule

// File: tb/tb_flex_tap_mac.sv
// tb_flex_tap_mac: directed tests of flex_tap_mac with hand-computed sums.
module tb_flex_tap_mac;
    logic               iClk_12M = 1'b0;
    logic               iRsn = 1'b0;
    logic               iEnDelay = 1'b0;
    logic signed [2:0]  iFirIn = '0;
    logic               iMacEn = 1'b0;
    logic [3:0]         iInSel = '0;
    logic signed [15:0] iCoef = '0;
    logic signed [22:0] oAccOut;
    logic               oAccValid, oBusy, oOverrun;
    int nChecks = 0;
    int nFail = 0;
    int validCnt = 0;
    int v0;

    flex_tap_mac dut (
        .iClk_12M(iClk_12M), .iRsn(iRsn), .iEnDelay(iEnDelay), .iFirIn(iFirIn),
        .iMacEn(iMacEn), .iInSel(iInSel), .iCoef(iCoef), .oAccOut(oAccOut),
        .oAccValid(oAccValid), .oBusy(oBusy), .oOverrun(oOverrun)
    );

    always #5 iClk_12M = ~iClk_12M;
    always @(posedge iClk_12M) if (oAccValid) validCnt++;

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge iClk_12M);
        #1;
    endtask

    task automatic quiet();
        iMacEn = 1'b0;
        iInSel = '0;
        iCoef  = '0;
    endtask

    task automatic sample(input logic signed [2:0] x);
        iEnDelay = 1'b1;
        iFirIn   = x;
        cyc();
        iEnDelay = 1'b0;
    endtask

    task automatic sweep(input logic signed [15:0] c0, input int step, input int n);
        for (int i = 0; i < n; i++) begin
            iMacEn = 1'b1;
            iInSel = 4'(i);
            iCoef  = 16'(int'(c0) + step * i);
            cyc();
        end
    endtask

    task automatic do_reset();
        quiet();
        iEnDelay = 1'b0;
        iRsn = 1'b0;
        cyc(2);
        iRsn = 1'b1;
    endtask

    task automatic test_reset();
        quiet();
        iRsn = 1'b0;
        cyc(2);
        nChecks++; if (oAccOut !== 23'sd0) begin nFail++; $display("FAIL reset_acc: got %0d want 0", oAccOut); end
        nChecks++; if (oAccValid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b want 0", oAccValid); end
        nChecks++; if (oBusy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b want 0", oBusy); end
        nChecks++; if (oOverrun !== 1'b0) begin nFail++; $display("FAIL reset_overrun: got %b want 0", oOverrun); end
        iRsn = 1'b1;
    endtask

    task automatic test_impulse();
        do_reset();
        iMacEn = 1'b1; iInSel = 4'd0; iCoef = 16'sd100;
        sample(3'sd1);
        nChecks++; if (oBusy !== 1'b1) begin nFail++; $display("FAIL impulse_busy: got %b want 1", oBusy); end
        sweep(16'sd1, 1, 10);
        nChecks++; if (oAccValid !== 1'b1) begin nFail++; $display("FAIL impulse_valid: got %b want 1", oAccValid); end
        nChecks++; if (oAccOut !== 23'sd1) begin nFail++; $display("FAIL impulse_sum: got %0d want 1", oAccOut); end
        quiet();
        cyc();
        nChecks++; if (oAccValid !== 1'b0) begin nFail++; $display("FAIL impulse_valid_pulse: got %b want 0", oAccValid); end
        nChecks++; if (oBusy !== 1'b0) begin nFail++; $display("FAIL impulse_idle: got %b want 0", oBusy); end
    endtask

    task automatic test_dc();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            sample(3'sd1);
            sweep(16'sd1, 1, 10);
            nChecks++; if (oAccValid !== 1'b1 || oAccOut !== 23'(k * (k + 1) / 2)) begin
                nFail++; $display("FAIL dc_sum_%0d: got %0d valid %b want %0d valid 1", k, oAccOut, oAccValid, k * (k + 1) / 2);
            end
            quiet();
            cyc();
        end
    endtask

    task automatic test_extreme();
        do_reset();
        repeat (10) sample(-3'sd4);
        sweep(16'sh8000, 0, 10);
        nChecks++; if (oAccOut !== 23'sd1310720) begin nFail++; $display("FAIL extreme_pos: got %0d want 1310720", oAccOut); end
        quiet();
        cyc();
        sample(-3'sd4);
        sweep(16'sh7fff, 0, 10);
        nChecks++; if (oAccOut !== -23'sd1310680) begin nFail++; $display("FAIL extreme_neg: got %0d want -1310680", oAccOut); end
        quiet();
        cyc();
    endtask

    // Delay line holds nine -4 samples from the previous test
    task automatic test_held_index();
        v0 = validCnt;
        sample(3'sd1);
        sweep(16'sd1, 1, 10);
        nChecks++; if (oAccOut !== -23'sd215) begin nFail++; $display("FAIL held_sum: got %0d want -215", oAccOut); end
        cyc(5);
        nChecks++; if (validCnt - v0 !== 1) begin nFail++; $display("FAIL held_valid_count: got %0d want 1", validCnt - v0); end
        nChecks++; if (oAccOut !== -23'sd215) begin nFail++; $display("FAIL held_no_accum: got %0d want -215", oAccOut); end
        nChecks++; if (oBusy !== 1'b0) begin nFail++; $display("FAIL held_idle: got %b want 0", oBusy); end
        quiet();
    endtask

    task automatic test_overrun();
        do_reset();
        sample(3'sd1);
        sweep(16'sd1, 1, 4);
        v0 = validCnt;
        quiet();
        sample(3'sd2);
        nChecks++; if (oOverrun !== 1'b1) begin nFail++; $display("FAIL overrun_pulse: got %b want 1", oOverrun); end
        nChecks++; if (oBusy !== 1'b1 || oAccValid !== 1'b0) begin nFail++; $display("FAIL overrun_state: got busy %b valid %b want busy 1 valid 0", oBusy, oAccValid); end
        cyc();
        nChecks++; if (oOverrun !== 1'b0) begin nFail++; $display("FAIL overrun_single: got %b want 0", oOverrun); end
        sweep(16'sd1, 1, 10);
        nChecks++; if (oAccOut !== 23'sd4) begin nFail++; $display("FAIL overrun_resweep: got %0d want 4", oAccOut); end
        quiet();
        cyc();
        nChecks++; if (validCnt - v0 !== 1) begin nFail++; $display("FAIL overrun_valid_count: got %0d want 1", validCnt - v0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sample(3'sd1);
        sweep(16'sd1, 1, 10);
        quiet();
        iEnDelay = 1'b1;
        iFirIn = 3'sd1;
        nChecks++; if (oAccValid !== 1'b1 || oAccOut !== 23'sd1) begin nFail++; $display("FAIL b2b_done: got %0d valid %b want 1 valid 1", oAccOut, oAccValid); end
        cyc();
        iEnDelay = 1'b0;
        nChecks++; if (oBusy !== 1'b1 || oAccValid !== 1'b0 || oOverrun !== 1'b0) begin
            nFail++; $display("FAIL b2b_restart: got busy %b valid %b ovr %b want 1 0 0", oBusy, oAccValid, oOverrun);
        end
        sweep(16'sd1, 1, 10);
        nChecks++; if (oAccOut !== 23'sd3) begin nFail++; $display("FAIL b2b_sum: got %0d want 3", oAccOut); end
        quiet();
        cyc();
    endtask

    task automatic test_async_reset();
        do_reset();
        sample(3'sd3);
        sweep(16'sd1, 1, 10);
        quiet();
        cyc();
        sample(3'sd1);
        sweep(16'sd1, 1, 5);
        #2 iRsn = 1'b0;
        #1;
        nChecks++; if (oAccOut !== 23'sd0) begin nFail++; $display("FAIL async_acc: got %0d want 0", oAccOut); end
        nChecks++; if (oBusy !== 1'b0) begin nFail++; $display("FAIL async_busy: got %b want 0", oBusy); end
        quiet();
        cyc();
        iRsn = 1'b1;
        sample(3'sd1);
        sweep(16'sd1, 1, 10);
        nChecks++; if (oAccOut !== 23'sd1) begin nFail++; $display("FAIL async_taps_cleared: got %0d want 1", oAccOut); end
        quiet();
        cyc();
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_extreme();
        test_held_index();
        test_overrun();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
